// File: rtl/pll_ctrl_pkg.sv
// PLL lock controller: shared state encoding and widths.
package pll_ctrl_pkg;

    localparam int CNT_W   = 16;
    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        ST_FAIL   = 3'd4
    } pll_state_t;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL LOCK pin into the clk_i domain.
module pll_lock_sync (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: reset pulse, lock wait, stability filter,
// retry/timeout handling and downstream reset release.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned STABLE_CYCLES  = 256,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          BYPASS_ON_FAIL = 1'b1
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       restart_i,
    input  logic       lock_i,
    output logic       pll_resetb_o,
    output logic       pll_bypass_o,
    output logic       rstn_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [3:0] retries_o
);

    localparam logic [CNT_W-1:0] RST_LAST =
        CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST =
        CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX =
        RETRY_W'(MAX_RETRIES);

    logic               lock_s;
    pll_state_t         state;
    pll_state_t         state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [RETRY_W-1:0] retries_n;

    pll_lock_sync u_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (lock_i),
        .q_o    (lock_s)
    );

    always_comb begin
        state_n   = state;
        retries_n = retries_o;
        cnt_n     = cnt + 1'b1;
        if (restart_i) begin
            state_n   = PLL_RST;
            retries_n = '0;
        end else begin
            unique case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST)
                        state_n = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // a lock seen on the timeout cycle still wins
                    if (lock_s) begin
                        state_n = STABLE;
                    end else if (cnt == TMO_LAST) begin
                        if (retries_o < RETRY_MAX) begin
                            state_n   = PLL_RST;
                            retries_n = retries_o + 1'b1;
                        end else begin
                            state_n = ST_FAIL;
                        end
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_n = WAIT_LOCK;
                    end else if (cnt == STB_LAST) begin
                        state_n   = RUN;
                        retries_n = '0;
                    end
                end
                RUN: begin
                    if (!lock_s)
                        state_n = PLL_RST;
                end
                ST_FAIL: begin
                    state_n = ST_FAIL;
                end
                default: begin
                    state_n = PLL_RST;
                end
            endcase
        end
        if (restart_i || (state_n != state))
            cnt_n = '0;
    end

    // outputs decoded from next state so they switch with the state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= PLL_RST;
            cnt          <= '0;
            retries_o    <= '0;
            pll_resetb_o <= 1'b0;
            pll_bypass_o <= 1'b0;
            rstn_o       <= 1'b0;
            locked_o     <= 1'b0;
            fail_o       <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            retries_o    <= retries_n;
            pll_resetb_o <= (state_n != PLL_RST);
            pll_bypass_o <= BYPASS_ON_FAIL &&
                            (state_n == ST_FAIL);
            rstn_o       <= (state_n == RUN) ||
                            (BYPASS_ON_FAIL &&
                             (state_n == ST_FAIL));
            locked_o     <= (state_n == RUN);
            fail_o       <= (state_n == ST_FAIL);
        end
    end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16, meaning cycles pll_resetb_o is held low per attempt (range 1..65535).
REQ-002 SHALL have parameter STABLE_CYCLES, default 256, meaning consecutive synced-lock cycles required before release (range 1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning maximum WAIT_LOCK cycles per attempt (range 1..65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 3, meaning re-attempts after the first before FAIL (range 0..15).
REQ-005 SHALL have parameter BYPASS_ON_FAIL, default 1, meaning in FAIL drive pll_bypass_o=1 and release rstn_o.
REQ-006 SHALL have port clk_i  in  1  reference clock; single clock domain.
REQ-007 SHALL have port rstn_i  in  1  asynchronous active-low reset.
REQ-008 SHALL have port restart_i  in  1  synchronous pulse; aborts and restarts the sequence and clears retries.
REQ-009 SHALL have port lock_i  in  1  PLL LOCK, asynchronous to clk_i.
REQ-010 SHALL have port pll_resetb_o  out  1  PLL RESETB, active low.
REQ-011 SHALL have port pll_bypass_o  out  1  PLL BYPASS.
REQ-012 SHALL have port rstn_o  out  1  downstream active-low reset.
REQ-013 SHALL have port locked_o  out  1  high iff state is RUN.
REQ-014 SHALL have port fail_o  out  1  high iff state is FAIL.
REQ-015 SHALL have port retries_o  out  4  attempts consumed in the current series.

Function
REQ-016 SHALL synchronize lock_i through 2 flops (lock_s), so lock_s is valid 2 cycles after a lock_i edge.
REQ-017 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN and FAIL with one shared 16-bit counter (cnt) cleared on every state change.
REQ-018 PLL_RST SHALL drive pll_resetb_o=0 for exactly RESET_CYCLES cycles, then go to WAIT_LOCK.
REQ-019 WAIT_LOCK SHALL go to STABLE when lock_s=1; otherwise at cnt=TIMEOUT_CYCLES-1 it SHALL go to PLL_RST with retries+1 if retries<MAX_RETRIES, else to FAIL.
REQ-020 WAIT_LOCK SHALL give lock_s=1 priority when lock_s=1 and the timeout fall in the same cycle.
REQ-021 STABLE SHALL go to RUN after STABLE_CYCLES consecutive cycles of lock_s=1, and SHALL return to WAIT_LOCK (timeout restarted) on any lock_s=0.
REQ-022 On entry to RUN the block SHALL clear retries to 0.
REQ-023 RUN SHALL go to PLL_RST on lock_s=0; this lock loss does not consume a retry.
REQ-024 FAIL SHALL hold until restart_i or rstn_i.
REQ-025 restart_i SHALL force PLL_RST and retries=0 from any state, with priority over all other transitions.
REQ-026 All outputs SHALL be registered and decoded from next-state.
REQ-027 rstn_o SHALL be 1 only in RUN, or in FAIL when BYPASS_ON_FAIL=1; it SHALL fall in the same cycle the state leaves RUN.
REQ-028 pll_bypass_o SHALL be 1 only in FAIL when BYPASS_ON_FAIL=1.
REQ-029 pll_resetb_o SHALL be 0 only in PLL_RST.
REQ-030 Latency from a lock_i fall in RUN to rstn_o=0 SHALL be at most 3 clk_i cycles.

Reset
REQ-031 While rstn_i=0: state=PLL_RST, cnt=0, retries_o=0, sync flops=0, pll_resetb_o=0, pll_bypass_o=0, rstn_o=0, locked_o=0, fail_o=0.
REQ-032 On rstn_i deassertion the block SHALL start a full PLL_RST period of RESET_CYCLES cycles.
REQ-033 rstn_i assertion mid-sequence SHALL take effect asynchronously and force rstn_o=0 immediately.

Structure
REQ-034 State encoding and counter width localparams SHALL live in shared package pll_ctrl_pkg.
REQ-035 The 2-flop synchronizer SHALL be sub-module pll_lock_sync (clk_i, rstn_i, d_i, q_o).
REQ-036 The RTL SHALL be synthesizable for iCE40 and used alongside SB_PLL40_CORE, with its simulation model driving lock_i.

Verification (RESET_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2, BYPASS_ON_FAIL=1)
REQ-037 Lock rises 10 cycles after pll_resetb_o rises -> rstn_o=1 and locked_o=1 exactly 2+8 cycles after the lock_i edge (±1 sync cycle); pll_resetb_o low for exactly 4 cycles.
REQ-038 lock_i never rises -> three PLL_RST pulses each 4 cycles wide, spaced 32 cycles apart; retries_o goes 0,1,2; then fail_o=1, pll_bypass_o=1, rstn_o=1.
REQ-039 lock_i glitches low for 1 cycle during STABLE -> return to WAIT_LOCK; RUN is reached only after 8 further clean cycles.
REQ-040 lock_i drops in RUN -> rstn_o=0 within 3 cycles, one 4-cycle PLL_RST pulse, retries_o stays 0.
REQ-041 restart_i in FAIL, and separately rstn_i low mid-STABLE -> PLL_RST entered, retries_o=0, all outputs at their reset values.
